// File: rtl/sysid_pkg.sv
// Shared definitions for the system-ID slave: register offsets, CAPS layout,
// read-pipe entry and a byte-lane merge helper.
package sysid_pkg;

  localparam logic [2:0] SYSID_OFF_ID        = 3'd0;
  localparam logic [2:0] SYSID_OFF_TIMESTAMP = 3'd1;
  localparam logic [2:0] SYSID_OFF_SCRATCH   = 3'd2;
  localparam logic [2:0] SYSID_OFF_UPTIME_LO = 3'd3;
  localparam logic [2:0] SYSID_OFF_UPTIME_HI = 3'd4;
  localparam logic [2:0] SYSID_OFF_CAPS      = 3'd5;
  localparam logic [2:0] SYSID_OFF_SECONDS   = 3'd6;

  localparam logic [15:0] SYSID_VERSION = 16'h0002;

  typedef struct packed {
    logic [15:0] version;
    logic [7:0]  rsvd_b;
    logic [3:0]  rsvd_n;
    logic [3:0]  rd_latency;
  } sysid_caps_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } sysid_rd_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    be_merge = old_v;
    for (int i = 0; i < 4; i++)
      if (be[i]) be_merge[8*i +: 8] = new_v[8*i +: 8];
  endfunction

endpackage

// File: rtl/sysid_rd_pipe.sv
// Fixed-latency read return pipe; data is captured at request time and
// only the valid bits are reset, so a reset drops everything in flight.
module sysid_rd_pipe
  import sysid_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  sysid_rd_t   req,
  output logic        valid,
  output logic [31:0] data
);

  logic [DEPTH-1:0]       vld_pipe;
  logic [DEPTH-1:0][31:0] dat_pipe;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= req.valid;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  always_ff @(posedge clock) begin
    dat_pipe[0] <= req.data;
    for (int i = 1; i < DEPTH; i++) dat_pipe[i] <= dat_pipe[i-1];
  end

  assign valid = vld_pipe[DEPTH-1];
  assign data  = valid ? dat_pipe[DEPTH-1] : 32'h0;

endmodule

// File: rtl/sysid_qsys_ext.sv
// System-ID Avalon-MM slave: ID/timestamp, scratch, 64-bit uptime with
// LO-triggered HI snapshot, seconds counter and capability word.
module sysid_qsys_ext
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSID_ID     = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
  parameter int          CLK_HZ       = 50_000_000,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam int             PW        = $clog2(CLK_HZ);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(CLK_HZ - 1);

  logic [63:0]   uptime;
  logic [31:0]   snap_hi;
  logic [31:0]   scratch;
  logic [31:0]   seconds;
  logic [PW-1:0] prescaler;
  logic [31:0]   rd_data;
  sysid_caps_t   caps;

  assign caps = '{version: SYSID_VERSION, rsvd_b: 8'h00, rsvd_n: 4'h0,
                  rd_latency: 4'(READ_LATENCY)};

  always_comb begin
    rd_data = 32'h0;
    case (address)
      SYSID_OFF_ID:        rd_data = SYSID_ID;
      SYSID_OFF_TIMESTAMP: rd_data = TIMESTAMP;
      SYSID_OFF_SCRATCH:   rd_data = scratch;
      SYSID_OFF_UPTIME_LO: rd_data = uptime[31:0];
      SYSID_OFF_UPTIME_HI: rd_data = snap_hi;
      SYSID_OFF_CAPS:      rd_data = caps;
      SYSID_OFF_SECONDS:   rd_data = seconds;
      default:             rd_data = 32'h0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      uptime    <= '0;
      snap_hi   <= '0;
      scratch   <= SCRATCH_INIT;
      seconds   <= '0;
      prescaler <= '0;
    end else begin
      uptime <= uptime + 64'd1;
      // HI is latched together with LO so a LO-then-HI pair is coherent
      if (read && address == SYSID_OFF_UPTIME_LO) snap_hi <= uptime[63:32];
      if (write && address == SYSID_OFF_SCRATCH)
        scratch <= be_merge(scratch, writedata, byteenable);
      if (write && address == SYSID_OFF_SECONDS) begin
        seconds   <= be_merge(seconds, writedata, byteenable);
        prescaler <= '0;
      end else if (prescaler == PRESC_MAX) begin
        seconds   <= seconds + 32'd1;
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  sysid_rd_pipe #(.DEPTH(READ_LATENCY)) u_rd_pipe (
    .clock (clock),
    .reset (reset),
    .req   ('{valid: read, data: rd_data}),
    .valid (readdatavalid),
    .data  (readdata)
  );

endmodule

// File: tb/tb_sysid_qsys_ext.sv
// Directed bench for sysid_qsys_ext with READ_LATENCY=3 and CLK_HZ=4.
module tb_sysid_qsys_ext;

  localparam logic [31:0] ID = 32'h5EED_1D01;
  localparam logic [31:0] TS = 32'h6512_3456;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  int vectors = 0;
  int miscompares = 0;

  sysid_qsys_ext #(
    .SYSID_ID(ID), .TIMESTAMP(TS), .CLK_HZ(4), .READ_LATENCY(3),
    .SCRATCH_INIT(32'h0)
  ) dut (
    .clock(clock), .reset(reset), .address(address), .read(read),
    .write(write), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // single read, checked 3 cycles after the request
  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    address = a; read = 1'b1;
    @(negedge clock); read = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk({tag, "_vld"}, readdatavalid, 1'b1);
    chk(tag, readdata, exp);
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = 3'd0;
    writedata = 32'h0; byteenable = 4'h0;
    repeat (3) @(negedge clock);
    chk("rst_vld", readdatavalid, 1'b0);
    chk("rst_data", readdata, 32'h0);
    chk("rst_scratch", dut.scratch, 32'h0);
    chk("rst_uptime", dut.uptime, 64'h0);
    chk("rst_seconds", dut.seconds, 32'h0);
    chk("rst_presc", dut.prescaler, 2'd0);
    reset = 1'b0;

    // seconds: one tick every 4 cycles
    repeat (12) @(negedge clock);
    chk("sec_12", dut.seconds, 32'd3);
    chk("presc_12", dut.prescaler, 2'd0);
    repeat (3) @(negedge clock);
    chk("presc_3", dut.prescaler, 2'd3);
    address = 3'd6; writedata = 32'h10; byteenable = 4'hF; write = 1'b1;
    @(negedge clock); write = 1'b0;
    chk("sec_load", dut.seconds, 32'h10);
    chk("presc_clr", dut.prescaler, 2'd0);
    repeat (3) @(negedge clock);
    chk("sec_hold", dut.seconds, 32'h10);
    @(negedge clock);
    chk("sec_inc", dut.seconds, 32'h11);
    repeat (3) @(negedge clock);
    force dut.seconds = 32'hFFFF_FFFF;
    #1 release dut.seconds;
    @(negedge clock);
    chk("sec_wrap", dut.seconds, 32'h0);

    // back-to-back reads, latency 3
    address = 3'd0; read = 1'b1;
    @(negedge clock); chk("lat_c1", readdatavalid, 1'b0); address = 3'd1;
    @(negedge clock); chk("lat_c2", readdatavalid, 1'b0); address = 3'd5;
    @(negedge clock); read = 1'b0;
    chk("id_vld", readdatavalid, 1'b1);
    chk("id", readdata, ID);
    @(negedge clock);
    chk("ts_vld", readdatavalid, 1'b1);
    chk("ts", readdata, TS);
    @(negedge clock);
    chk("caps_vld", readdatavalid, 1'b1);
    chk("caps", readdata, 32'h0002_0003);
    @(negedge clock);
    chk("idle_vld", readdatavalid, 1'b0);
    chk("idle_data", readdata, 32'h0);

    rd_chk(3'd4, 32'h0, "snap_init");

    // scratch byte lanes, RO write ignored, read-during-write
    address = 3'd2; writedata = 32'hDEAD_BEEF; byteenable = 4'b0101; write = 1'b1;
    @(negedge clock); write = 1'b0;
    rd_chk(3'd2, 32'h00AD_00EF, "scratch_be");
    address = 3'd0; writedata = 32'h1; byteenable = 4'hF; write = 1'b1;
    @(negedge clock); write = 1'b0;
    rd_chk(3'd0, ID, "id_ro");
    address = 3'd7; writedata = 32'hFFFF_FFFF; write = 1'b1;
    @(negedge clock); write = 1'b0;
    rd_chk(3'd7, 32'h0, "rsvd");
    address = 3'd2; writedata = 32'h1122_3344; byteenable = 4'hF; write = 1'b1; read = 1'b1;
    @(negedge clock); write = 1'b0; read = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rw_old", readdata, 32'h00AD_00EF);
    rd_chk(3'd2, 32'h1122_3344, "rw_new");

    // uptime snapshot
    force dut.uptime = 64'h0000_0001_FFFF_FFFE;
    #1 release dut.uptime;
    address = 3'd3; read = 1'b1;
    @(negedge clock);
    chk("upt_inc", dut.uptime, 64'h0000_0001_FFFF_FFFF);
    address = 3'd4;
    @(negedge clock); read = 1'b0;
    @(negedge clock);
    chk("upt_lo", readdata, 32'hFFFF_FFFE);
    @(negedge clock);
    chk("upt_hi", readdata, 32'h1);
    rd_chk(3'd4, 32'h1, "upt_hi_again");

    force dut.uptime = 64'hFFFF_FFFF_FFFF_FFFF;
    #1 release dut.uptime;
    @(negedge clock);
    chk("upt_wrap", dut.uptime, 64'h0);

    // reset flushes in-flight reads
    address = 3'd0; read = 1'b1;
    @(negedge clock); address = 3'd1;
    @(negedge clock); read = 1'b0; reset = 1'b1;
    @(negedge clock);
    @(negedge clock); reset = 1'b0;
    chk("flush_scratch", dut.scratch, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("flush_vld", readdatavalid, 1'b0);
      chk("flush_data", readdata, 32'h0);
      @(negedge clock);
    end
    rd_chk(3'd2, 32'h0, "scratch_init");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
